// File: rtl/alu_seq_mdu_if.sv
// ----------------------------------------------------------------------------
// alu_seq_mdu_if
//   Request/result bundle between the operand-fetch stage, the execute unit
//   and writeback.
//
//   in_valid   request strobe                 (master -> slave)
//   in_ready   unit can accept                (slave  -> master)
//   op_sel     5-bit operation code           (master -> slave)
//   opdA/opdB  operands rs1 / rs2-or-imm      (master -> slave)
//   kill       pipeline flush                 (master -> slave)
//   out_valid  result available               (slave  -> master)
//   out_ready  consumer takes the result      (master -> slave)
//   out        registered result              (slave  -> master)
//   illegal    result is for an unsupported op (slave -> master)
// ----------------------------------------------------------------------------
interface alu_seq_mdu_if #(
   parameter int XLEN = 32
) ();
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      op_sel;
   logic [XLEN-1:0] opdA;
   logic [XLEN-1:0] opdB;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out;
   logic            illegal;

   modport master (
      output in_valid, op_sel, opdA, opdB, kill, out_ready,
      input  in_ready, out_valid, out, illegal
   );

   modport slave (
      input  in_valid, op_sel, opdA, opdB, kill, out_ready,
      output in_ready, out_valid, out, illegal
   );
endinterface

// File: rtl/alu_seq_mdu.sv
// ----------------------------------------------------------------------------
// alu_seq_mdu
//   Handshaked execute unit: RV32I integer ALU ops in one cycle plus optional
//   RV32M multiply/divide iterating one bit per cycle, result registered.
//
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   alu_seq_mdu_if.slave: in_valid/in_ready/op_sel/opdA/opdB/kill
//         request side, out_valid/out_ready/out/illegal result side
//
//   Parameters: XLEN (>=8, power of 2), MEXT (1 = M ops enabled).
// ----------------------------------------------------------------------------
module alu_seq_mdu #(
   parameter int XLEN = 32,
   parameter bit MEXT = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   alu_seq_mdu_if.slave bus
);
   localparam int SHW = $clog2(XLEN);

   localparam logic [4:0] OP_ADD  = 5'd0;
   localparam logic [4:0] OP_SUB  = 5'd1;
   localparam logic [4:0] OP_XOR  = 5'd2;
   localparam logic [4:0] OP_OR   = 5'd3;
   localparam logic [4:0] OP_AND  = 5'd4;
   localparam logic [4:0] OP_SRL  = 5'd5;
   localparam logic [4:0] OP_SRA  = 5'd6;
   localparam logic [4:0] OP_SLL  = 5'd7;
   localparam logic [4:0] OP_SLT  = 5'd8;
   localparam logic [4:0] OP_SLTU = 5'd9;

   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [SHW-1:0]    cnt_q, cnt_d;
   logic [2:0]        mop_q, mop_d;       // M sub-op: 0 MUL .. 7 REMU
   logic [2*XLEN-1:0] work_q, work_d;     // mul: {acc, multiplier}; div: {rem, quotient}
   logic [XLEN-1:0]   opnd_q, opnd_d;     // multiplicand / divisor magnitude
   logic              neg_q, neg_d;       // negate product / quotient at the end
   logic              neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]   out_q, out_d;
   logic              illegal_q, illegal_d;

   // ---------------------------------------------------------------------
   // Request decode (only meaningful in IDLE)
   // ---------------------------------------------------------------------
   logic [XLEN-1:0] a, b;
   logic [SHW-1:0]  shamt;
   logic            accept, is_base, is_m, legal, is_div;
   logic            a_signed, b_signed, a_neg, b_neg;
   logic [XLEN-1:0] a_mag, b_mag;
   logic            b_zero, ovf, fast;
   logic [XLEN-1:0] base_res, fast_res;

   assign a      = bus.opdA;
   assign b      = bus.opdB;
   assign shamt  = b[SHW-1:0];
   assign accept = bus.in_valid & (state_q == IDLE) & ~bus.kill;

   assign is_base = (bus.op_sel <= OP_SLTU);
   assign is_m    = (bus.op_sel[4:3] == 2'b10);
   assign legal   = is_base | (MEXT & is_m);
   assign is_div  = is_m & bus.op_sel[2];

   // Signed operand A: MULH, MULHSU, DIV, REM.  Signed operand B: MULH, DIV, REM.
   assign a_signed = is_m & ((bus.op_sel[2:0] == 3'd1) | (bus.op_sel[2:0] == 3'd2) |
                             (bus.op_sel[2] & ~bus.op_sel[0]));
   assign b_signed = is_m & ((bus.op_sel[2:0] == 3'd1) | (bus.op_sel[2] & ~bus.op_sel[0]));
   assign a_neg    = a_signed & a[XLEN-1];
   assign b_neg    = b_signed & b[XLEN-1];
   assign a_mag    = a_neg ? -a : a;
   assign b_mag    = b_neg ? -b : b;

   // Division corner cases resolved without iterating.
   assign b_zero   = (b == '0);
   assign ovf      = ~bus.op_sel[0] & (a == XMIN) & (b == '1);
   assign fast     = is_div & (b_zero | ovf);
   // op_sel[1] separates REM/REMU from DIV/DIVU.
   assign fast_res = b_zero ? (bus.op_sel[1] ? a : '1)
                            : (bus.op_sel[1] ? '0 : XMIN);

   always_comb begin
      base_res = '0;
      case (bus.op_sel)
         OP_ADD:  base_res = a + b;
         OP_SUB:  base_res = a - b;
         OP_XOR:  base_res = a ^ b;
         OP_OR:   base_res = a | b;
         OP_AND:  base_res = a & b;
         OP_SRL:  base_res = a >> shamt;
         OP_SRA:  base_res = $unsigned($signed(a) >>> shamt);
         OP_SLL:  base_res = a << shamt;
         OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
         default: base_res = '0;
      endcase
   end

   // ---------------------------------------------------------------------
   // One iteration of the shift-add multiplier / restoring divider
   // ---------------------------------------------------------------------
   logic [XLEN:0]     mul_sum, div_shift, div_diff;
   logic [XLEN-1:0]   div_rem;
   logic [2*XLEN-1:0] mul_next, div_next, step;

   // Multiply: add multiplicand into the upper half when the multiplier LSB
   // is set, then shift the whole product right; the carry fills the top bit.
   assign mul_sum  = {1'b0, work_q[2*XLEN-1:XLEN]} + (work_q[0] ? {1'b0, opnd_q} : '0);
   assign mul_next = {mul_sum, work_q[XLEN-1:1]};

   // Divide: shift the next dividend bit into the remainder and trial-subtract.
   // A borrow (diff MSB) means the divisor did not fit: keep the shifted value.
   assign div_shift = work_q[2*XLEN-1:XLEN-1];
   assign div_diff  = div_shift - {1'b0, opnd_q};
   assign div_rem   = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
   assign div_next  = {div_rem, work_q[XLEN-2:0], ~div_diff[XLEN]};

   assign step = mop_q[2] ? div_next : mul_next;

   // Sign fix-up of the final iteration's value.
   logic [2*XLEN-1:0] prod_fin;
   logic [XLEN-1:0]   quo_fin, rem_fin, m_res;

   assign prod_fin = neg_q ? -step : step;
   assign quo_fin  = neg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
   assign rem_fin  = neg_rem_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];

   always_comb begin
      m_res = '0;
      case (mop_q)
         3'd0:             m_res = prod_fin[XLEN-1:0];
         3'd1, 3'd2, 3'd3: m_res = prod_fin[2*XLEN-1:XLEN];
         3'd4, 3'd5:       m_res = quo_fin;
         default:          m_res = rem_fin;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM next state and datapath updates
   // ---------------------------------------------------------------------
   // NOTE: every _d gets its hold value first, so no path through this block
   //       leaves a variable unassigned and no latch is inferred.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mop_d     = mop_q;
      work_d    = work_q;
      opnd_d    = opnd_q;
      neg_d     = neg_q;
      neg_rem_d = neg_rem_q;
      out_d     = out_q;
      illegal_d = illegal_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               mop_d     = bus.op_sel[2:0];
               cnt_d     = '0;
               illegal_d = 1'b0;
               // Divide iterates over the dividend, multiply over the multiplier.
               work_d    = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
               opnd_d    = is_div ? b_mag : a_mag;
               neg_d     = a_neg ^ b_neg;
               neg_rem_d = a_neg;
               if (!legal) begin
                  out_d     = '0;
                  illegal_d = 1'b1;
                  state_d   = DONE;
               end else if (!is_m) begin
                  out_d   = base_res;
                  state_d = DONE;
               end else if (fast) begin
                  out_d   = fast_res;
                  state_d = DONE;
               end else begin
                  state_d = EXEC;
               end
            end
         end

         EXEC: begin
            if (bus.kill) begin
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               work_d = step;
               cnt_d  = cnt_q + 1'b1;   // wraps to 0 after the last iteration
               if (cnt_q == SHW'(XLEN-1)) begin
                  out_d   = m_res;
                  state_d = DONE;
               end
            end
         end

         DONE: begin
            if (bus.kill || bus.out_ready) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop
   //       samples the values from before the edge, independent of order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         mop_q     <= '0;
         work_q    <= '0;
         opnd_q    <= '0;
         neg_q     <= 1'b0;
         neg_rem_q <= 1'b0;
         out_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         mop_q     <= mop_d;
         work_q    <= work_d;
         opnd_q    <= opnd_d;
         neg_q     <= neg_d;
         neg_rem_q <= neg_rem_d;
         out_q     <= out_d;
         illegal_q <= illegal_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out       = out_q;
   assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_seq_mdu.sv
// ----------------------------------------------------------------------------
// tb_alu_seq_mdu
//   Bench for alu_seq_mdu: a 32-bit unit with M ops (directed corner cases
//   plus random ops against an arithmetic reference) and a 16-bit unit
//   without M ops.
// ----------------------------------------------------------------------------
module tb_alu_seq_mdu;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   alu_seq_mdu_if #(.XLEN(32)) b32 ();
   alu_seq_mdu_if #(.XLEN(16)) b16 ();

   alu_seq_mdu #(.XLEN(32), .MEXT(1'b1)) dut32 (.clk(clk), .rst(rst), .bus(b32));
   alu_seq_mdu #(.XLEN(16), .MEXT(1'b0)) dut16 (.clk(clk), .rst(rst), .bus(b16));

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: plain 64-bit arithmetic on the operation's definition
   // ---------------------------------------------------------------------
   localparam logic [31:0] MIN32 = 32'h8000_0000;

   function automatic logic [31:0] model32(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, output logic ill,
                                           output int lat);
      logic [63:0] ea, eb, p;
      logic [31:0] r;
      ill = 1'b0;
      lat = 1;
      r   = '0;
      case (op)
         5'd0:  r = a + b;
         5'd1:  r = a - b;
         5'd2:  r = a ^ b;
         5'd3:  r = a | b;
         5'd4:  r = a & b;
         5'd5:  r = a >> b[4:0];
         5'd6:  r = $signed(a) >>> b[4:0];
         5'd7:  r = a << b[4:0];
         5'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'd9:  r = (a < b) ? 32'd1 : 32'd0;
         5'd16, 5'd17, 5'd18, 5'd19: begin
            lat = 33;
            ea  = (op == 5'd17 || op == 5'd18) ? {{32{a[31]}}, a} : {32'd0, a};
            eb  = (op == 5'd17) ? {{32{b[31]}}, b} : {32'd0, b};
            p   = ea * eb;
            r   = (op == 5'd16) ? p[31:0] : p[63:32];
         end
         5'd20: begin
            if (b == 0) r = '1;
            else if (a == MIN32 && b == '1) r = MIN32;
            else begin lat = 33; r = $signed(a) / $signed(b); end
         end
         5'd21: begin
            if (b == 0) r = '1;
            else begin lat = 33; r = a / b; end
         end
         5'd22: begin
            if (b == 0) r = a;
            else if (a == MIN32 && b == '1) r = '0;
            else begin lat = 33; r = $signed(a) % $signed(b); end
         end
         5'd23: begin
            if (b == 0) r = a;
            else begin lat = 33; r = a % b; end
         end
         default: begin ill = 1'b1; r = '0; end
      endcase
      return r;
   endfunction

   // ---------------------------------------------------------------------
   // Drivers
   // ---------------------------------------------------------------------
   // Issue one op on the 32-bit unit, wait for out_valid (bounded), return
   // result and the number of edges from accept to out_valid, then hand it off.
   task automatic do_op32(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic ill, output int lat);
      @(negedge clk);
      check("in_ready_idle", b32.in_ready, 1'b1);
      b32.in_valid  = 1'b1;
      b32.op_sel    = op;
      b32.opdA      = a;
      b32.opdB      = b;
      b32.out_ready = 1'b1;
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      b32.opdA     = $urandom;        // operands must have been captured
      b32.opdB     = $urandom;
      b32.op_sel   = 5'($urandom);
      lat = 1;
      while (!b32.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!b32.out_valid) check("out_valid_timeout", 1'b0, 1'b1);
      res = b32.out;
      ill = b32.illegal;
      @(posedge clk); #1;             // handshake edge
   endtask

   task automatic run32(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      logic [31:0] res, exp;
      logic        ill, exp_ill;
      int          lat, exp_lat;
      exp = model32(op, a, b, exp_ill, exp_lat);
      do_op32(op, a, b, res, ill, lat);
      check({tag, "_out"}, res, exp);
      check({tag, "_ill"}, ill, exp_ill);
      check({tag, "_lat"}, lat, exp_lat);
   endtask

   task automatic do_op16(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] res, output logic ill, output int lat);
      @(negedge clk);
      b16.in_valid  = 1'b1;
      b16.op_sel    = op;
      b16.opdA      = a;
      b16.opdB      = b;
      b16.out_ready = 1'b1;
      @(posedge clk); #1;
      b16.in_valid = 1'b0;
      lat = 1;
      while (!b16.out_valid && lat < 50) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!b16.out_valid) check("out16_valid_timeout", 1'b0, 1'b1);
      res = b16.out;
      ill = b16.illegal;
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] rand_opnd();
      logic [31:0] specials [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                    32'h7FFF_FFFF, 32'h2};
      case ($urandom_range(0, 3))
         0:       return specials[$urandom_range(0, 5)];
         1:       return 32'($urandom_range(0, 20)) - 32'd10;
         default: return $urandom;
      endcase
   endfunction

   // ---------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------
   logic [4:0] codes [22] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                              5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23,
                              5'd10, 5'd15, 5'd24, 5'd31};

   initial begin
      logic [31:0] res, held;
      logic [15:0] res16;
      logic        ill;
      int          lat;

      rst = 1'b1;
      b32.in_valid = 1'b0; b32.op_sel = '0; b32.opdA = '0; b32.opdB = '0;
      b32.kill = 1'b0; b32.out_ready = 1'b0;
      b16.in_valid = 1'b0; b16.op_sel = '0; b16.opdA = '0; b16.opdB = '0;
      b16.kill = 1'b0; b16.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", b32.in_ready, 1'b1);
      check("rst_out_valid", b32.out_valid, 1'b0);
      check("rst_out", b32.out, 32'h0);
      check("rst_illegal", b32.illegal, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Base ops
      run32("add_wrap", 5'd0, 32'hFFFF_FFFF, 32'h1);
      run32("sra_min", 5'd6, 32'h8000_0000, 32'd31);
      run32("slt_neg", 5'd8, 32'hFFFF_FFFF, 32'h1);
      run32("sltu_neg", 5'd9, 32'hFFFF_FFFF, 32'h1);
      // Multiply
      run32("mulh_m2x3", 5'd17, 32'hFFFF_FFFE, 32'd3);
      run32("mul_m2x3", 5'd16, 32'hFFFF_FFFE, 32'd3);
      run32("mulhu_max", 5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      run32("mulhsu", 5'd18, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      // Divide
      run32("div_m7_2", 5'd20, 32'hFFFF_FFF9, 32'd2);
      run32("rem_m7_2", 5'd22, 32'hFFFF_FFF9, 32'd2);
      run32("divu_by0", 5'd21, 32'd5, 32'd0);
      run32("rem_by0", 5'd22, 32'd5, 32'd0);
      run32("div_ovf", 5'd20, 32'h8000_0000, 32'hFFFF_FFFF);
      run32("rem_ovf", 5'd22, 32'h8000_0000, 32'hFFFF_FFFF);
      run32("illegal_op", 5'd12, 32'd5, 32'd6);
      run32("ill_clear", 5'd0, 32'd5, 32'd6);

      // Backpressure: result held for 5 cycles, no new accept possible
      @(negedge clk);
      b32.in_valid = 1'b1; b32.op_sel = 5'd1; b32.opdA = 32'd10; b32.opdB = 32'd3;
      b32.out_ready = 1'b0;
      @(posedge clk); #1;
      check("bp_valid", b32.out_valid, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("bp_out_stable", b32.out, 32'd7);
         check("bp_valid_held", b32.out_valid, 1'b1);
         check("bp_in_ready", b32.in_ready, 1'b0);
      end
      b32.in_valid = 1'b0;
      @(negedge clk);
      b32.out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_in_ready", b32.in_ready, 1'b1);
      check("bp_release_valid", b32.out_valid, 1'b0);

      // kill blocks an accept in IDLE
      @(negedge clk);
      b32.in_valid = 1'b1; b32.kill = 1'b1; b32.op_sel = 5'd0;
      @(posedge clk); #1;
      b32.in_valid = 1'b0; b32.kill = 1'b0;
      check("kill_blocks_accept", b32.out_valid, 1'b0);
      check("kill_blocks_ready", b32.in_ready, 1'b1);

      // kill at EXEC iteration 10
      held = b32.out;
      @(negedge clk);
      b32.in_valid = 1'b1; b32.op_sel = 5'd20; b32.opdA = 32'd1000; b32.opdB = 32'd7;
      b32.out_ready = 1'b1;
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      check("exec_busy", b32.in_ready, 1'b0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      b32.kill = 1'b1;
      @(posedge clk); #1;
      b32.kill = 1'b0;
      check("kill_no_valid", b32.out_valid, 1'b0);
      check("kill_idle", b32.in_ready, 1'b1);
      check("kill_out_kept", b32.out, held);
      repeat (40) @(posedge clk);
      #1;
      check("kill_stays_quiet", b32.out_valid, 1'b0);
      run32("after_kill_add", 5'd0, 32'd2, 32'd3);

      // Reset in the middle of EXEC
      @(negedge clk);
      b32.in_valid = 1'b1; b32.op_sel = 5'd16; b32.opdA = 32'd9; b32.opdB = 32'd9;
      @(posedge clk); #1;
      b32.in_valid = 1'b0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      check("rst_exec_out", b32.out, 32'h0);
      check("rst_exec_valid", b32.out_valid, 1'b0);
      check("rst_exec_ready", b32.in_ready, 1'b1);
      check("rst_exec_illegal", b32.illegal, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // Random ops against the reference model
      for (int i = 0; i < 80; i++) begin
         run32("rand", codes[$urandom_range(0, 21)], rand_opnd(), rand_opnd());
      end

      // 16-bit unit without M ops
      do_op16(5'd16, 16'd3, 16'd4, res16, ill, lat);
      check("x16_mul_ill", ill, 1'b1);
      check("x16_mul_out", res16, 16'h0);
      check("x16_mul_lat", lat, 1);
      do_op16(5'd7, 16'd1, 16'h0013, res16, ill, lat);
      check("x16_sll_out", res16, 16'h0008);
      check("x16_sll_ill", ill, 1'b0);
      do_op16(5'd6, 16'h8000, 16'd15, res16, ill, lat);
      check("x16_sra_out", res16, 16'hFFFF);
      do_op16(5'd0, 16'hFFFF, 16'h0001, res16, ill, lat);
      check("x16_add_out", res16, 16'h0000);
      do_op16(5'd21, 16'd9, 16'd0, res16, ill, lat);
      check("x16_divu_ill", ill, 1'b1);
      check("x16_divu_out", res16, 16'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, tests run %0d", n_tests);
      $fatal(1, "watchdog expired");
   end

endmodule
